// File: rtl/wb_pkg.sv
// Shared types for the write-back unit: load size codes, load-queue entry
// layout and a small helper for building register masks.
package wb_pkg;

  // Load size/sign codes carried on ld_funct3
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // One queued load result: destination register plus the extended value
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lq_entry_t;

  // One-hot register mask for a 5-bit register index
  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_unit_load_extend.sv
// Load data extension: selects the addressed byte/halfword of the raw
// memory word and sign- or zero-extends it according to funct3.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes of the memory word
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane; LW and unknown codes pass the word through
  always_comb begin
    data = rdata;
    case (funct3_e'(funct3))
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'h000000, byte_sel};
      F3_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: merges ALU results (never stalled, highest priority)
// with load returns buffered in a small FIFO onto one register-file write
// port, and reports which registers still have a queued load result.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic        we,
  output logic [4:0]  rd,
  output logic [31:0] wd,
  output logic [31:0] pending
);

  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  lq_entry_t         mem_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] valid_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              rdy_en_q;

  logic              we_q;
  logic [4:0]        rd_q;
  logic [31:0]       wd_q;

  logic [31:0]       ext_data;
  logic              push;
  logic              pop;
  lq_entry_t         head;
  logic [31:0]       pending_w;

  load_extend u_ext (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (ld_rdata),
    .data    (ext_data)
  );

  // rdy_en_q keeps ld_ready low while in reset even though the queue is empty
  assign ld_ready = rdy_en_q && (count_q < CW'(LQ_DEPTH));
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  // Pending mask: OR of one-hot destinations of every occupied queue slot
  always_comb begin
    pending_w = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (valid_q[i[PW-1:0]]) begin
        pending_w = pending_w | onehot32(mem_q[i[PW-1:0]].rd);
      end
    end
    pending_w[0] = 1'b0;
  end

  assign pending = pending_w;

  // Load queue storage, pointers, occupancy and ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        mem_q[i[PW-1:0]] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      // A pop and a push never target the same slot: push needs a free
      // slot and pop needs an occupied one.
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q]   <= '{rd: ld_rd, data: ext_data};
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Register-file write port: ALU first, then queue head; x0 writes suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      rd_q <= '0;
      wd_q <= '0;
    end else if (alu_valid) begin
      we_q <= (alu_rd != 5'd0);
      rd_q <= alu_rd;
      wd_q <= alu_result;
    end else if (pop) begin
      we_q <= (head.rd != 5'd0);
      rd_q <= head.rd;
      wd_q <= head.data;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign we = we_q;
  assign rd = rd_q;
  assign wd = wd_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: queue-based reference model feeding a
// scoreboard of expected register writes, checked by a negedge monitor.
module tb_wb_unit;
  import wb_pkg::*;

  localparam int unsigned LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_funct3 = '0;
  logic [1:0]  ld_addr_lo = '0;
  logic [31:0] ld_rdata = '0;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] pending;

  always #5 clk = ~clk;

  wb_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_rdata   (ld_rdata),
    .we         (we),
    .rd         (rd),
    .wd         (wd),
    .pending    (pending)
  );

  typedef struct { int due; logic [4:0] rd; logic [31:0] wd; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] v; } ld_t;

  wr_t exp_q[$];
  ld_t lq[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  m_en = 1'b0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Load value from the ISA rules, using shifts and masks on the word
  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Reference model: ALU wins, otherwise the oldest queued load is written
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq.delete();
      exp_q.delete();
      m_en = 1'b0;
    end else begin
      bit acc;
      ld_t e;
      acc = ld_valid && m_en && (lq.size() < LQ_DEPTH);
      if (alu_valid) begin
        if (alu_rd != 5'd0) exp_q.push_back('{due: cyc + 1, rd: alu_rd, wd: alu_result});
      end else if (lq.size() > 0) begin
        e = lq.pop_front();
        if (e.rd != 5'd0) exp_q.push_back('{due: cyc + 1, rd: e.rd, wd: e.v});
      end
      if (acc) lq.push_back('{rd: ld_rd, v: ext(ld_funct3, ld_addr_lo, ld_rdata)});
      m_en = 1'b1;
      cyc++;
    end
  end

  // Monitor: compare outputs with the model half a cycle after each edge
  always @(negedge clk) begin
    logic [31:0] m_pend;
    wr_t e;
    m_pend = '0;
    foreach (lq[i]) m_pend[lq[i].rd] = 1'b1;
    m_pend[0] = 1'b0;
    if (!rst_n) begin
      chk("rst_we", {31'b0, we}, 32'd0);
      chk("rst_rd", {27'b0, rd}, 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    end else begin
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, (m_en && lq.size() < LQ_DEPTH)});
      chk("pending", pending, m_pend);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_we: got write rd=%0d wd=%h, expected no write (cycle %0d)",
                   rd, wd, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.due);
          chk("wr_rd", {27'b0, rd}, {27'b0, e.rd});
          chk("wr_wd", wd, e.wd);
        end
        last_wd = wd;
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_we: got we=%b, expected write rd=%0d wd=%h (cycle %0d)",
                 we, e.rd, e.wd, cyc);
      end
    end
  end

  // One cycle of stimulus; acc reports whether the offered load is taken
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      output bit acc);
    alu_valid  = av;
    alu_rd     = ard;
    alu_result = ares;
    acc = ld_valid && ld_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] r, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] w);
    ld_valid   = v;
    ld_rd      = r;
    ld_funct3  = f3;
    ld_addr_lo = off;
    ld_rdata   = w;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, a);
  endtask

  // Offer one load with the ALU idle, bounded wait for acceptance
  task automatic one_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] w);
    bit a;
    int k;
    offer(1'b1, r, f3, off, w);
    a = 1'b0;
    k = 0;
    while (!a && k < 20) begin
      step(1'b0, 5'd0, 32'd0, a);
      k++;
    end
    chk("load_accept_timeout", {31'b0, a}, 32'd1);
    offer(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
  endtask

  initial begin
    bit a;
    int n;
    // Reset and first-edge ready
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'b0, ld_ready}, 32'd1);

    // ALU back-to-back writes
    step(1'b1, 5'd1, 32'h11, a);
    step(1'b1, 5'd2, 32'h22, a);
    step(1'b1, 5'd3, 32'h33, a);
    idle(3);

    // Load extension cases
    one_load(5'd7, F3_LB, 2'd3, 32'h80FF7F01);
    idle(3);
    chk("ext_lb_off3", last_wd, 32'hFFFFFF80);
    one_load(5'd7, F3_LBU, 2'd1, 32'h80FF7F01);
    idle(3);
    chk("ext_lbu_off1", last_wd, 32'h0000007F);
    one_load(5'd7, F3_LH, 2'd2, 32'h80FF7F01);
    idle(3);
    chk("ext_lh_off2", last_wd, 32'hFFFF80FF);
    one_load(5'd7, F3_LHU, 2'd0, 32'h80FF7F01);
    idle(3);
    chk("ext_lhu_off0", last_wd, 32'h00007F01);

    // Back-pressure: ALU busy while three loads are offered
    n = 0;
    offer(1'b1, 5'd10, F3_LW, 2'd0, 32'hA000_0000);
    for (int c = 0; c < 20 && n < 3; c++) begin
      step(c < 5, 5'd20, 32'hC000_0000 + c, a);
      if (a) begin
        n++;
        if (n < 3) offer(1'b1, 5'(10 + n), F3_LW, 2'd0, 32'hA000_0000 + n);
        else offer(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      end
      if (n == 2 && c < 4) chk("bp_full_ready", {31'b0, ld_ready}, 32'd0);
    end
    chk("bp_all_accepted", n, 32'd3);
    idle(6);
    chk("bp_ready_back", {31'b0, ld_ready}, 32'd1);

    // x0 destinations are consumed but never written
    step(1'b1, 5'd0, 32'hDEAD_BEEF, a);
    one_load(5'd0, F3_LW, 2'd0, 32'h1234_5678);
    one_load(5'd0, F3_LB, 2'd0, 32'h0000_0080);
    idle(4);
    chk("x0_pending", pending, 32'd0);

    // Two loads to the same register stay pending until both retire
    offer(1'b1, 5'd5, F3_LW, 2'd0, 32'h5555_0001);
    step(1'b1, 5'd6, 32'h66, a);
    offer(1'b1, 5'd5, F3_LW, 2'd0, 32'h5555_0002);
    step(1'b1, 5'd6, 32'h67, a);
    offer(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("pend_both_queued", pending, 32'h20);
    step(1'b0, 5'd0, 32'd0, a);
    chk("pend_one_left", pending, 32'h20);
    idle(3);
    chk("pend_cleared", pending, 32'd0);
    chk("pend_last_value", last_wd, 32'h5555_0002);

    // Reset while two loads are queued
    offer(1'b1, 5'd8, F3_LW, 2'd0, 32'h8888_0001);
    step(1'b1, 5'd9, 32'h99, a);
    offer(1'b1, 5'd9, F3_LW, 2'd0, 32'h8888_0002);
    step(1'b1, 5'd9, 32'h9A, a);
    offer(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("rstq_pending_before", pending, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("rstq_pending_in_rst", pending, 32'd0);
    step(1'b0, 5'd0, 32'd0, a);
    step(1'b0, 5'd0, 32'd0, a);
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, a);
    chk("rstq_ready_after", {31'b0, ld_ready}, 32'd1);
    idle(4);

    // Randomized traffic with a stable valid/ready load offer
    offer(1'($urandom % 2), 5'($urandom % 8), 3'($urandom), 2'($urandom), $urandom);
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 3) == 0, 5'($urandom % 8), $urandom, a);
      if (a || !ld_valid) begin
        offer(1'($urandom % 2), 5'(($urandom % 4 == 0) ? $urandom : $urandom % 8),
              3'($urandom), 2'($urandom), $urandom);
      end
    end
    offer(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    idle(10);
    chk("drain_leftover", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
